// File: rtl/mtsp_of_pkg.sv
// Shared definitions for the Meitner operand-fetch phase-N stage: unit
// instruction field positions, stage states and the per-pair GPR read request.
package mtsp_of_pkg;

  localparam int GPR_AW = 7;
  localparam logic [31:0] NOP = 32'hFFFF_FFFF;

  localparam int F_NEN     = 31;
  localparam int F_NALU    = 30;
  localparam int F_MO_LO   = 28;
  localparam int F_SIB_LO  = 26;
  localparam int F_DEST_LO = 21;
  localparam int F_SRC_LO  = 16;

  typedef enum logic [1:0] {IDLE, BUSY, LAST} state_t;

  typedef struct packed {
    logic              nen;
    logic [GPR_AW-1:0] addr;
  } pair_req_t;

  // A pair reads a GPR unless both halves are disabled. The sub instruction's
  // source wins; a disabled sub falls back to the main instruction, where a
  // memory-op main (MO=11) reads the register after its SRC.
  function automatic pair_req_t pair_req(
    input logic       m_nen,
    input logic [1:0] m_mo,
    input logic [4:0] m_dest,
    input logic [4:0] m_src,
    input logic       s_nen,
    input logic       s_nalu,
    input logic [1:0] s_sib,
    input logic [4:0] s_src
  );
    pair_req_t  r;
    logic [1:0] hi;
    logic [4:0] lo;
    hi = s_nalu ? 2'b00 : s_sib;
    if (!s_nen)
      lo = s_src;
    else if (&m_mo)
      lo = m_src + 5'd1;
    else
      lo = m_dest;
    r.nen  = m_nen & s_nen;
    r.addr = {hi, lo};
    return r;
  endfunction

endpackage

// File: rtl/mtsp_of_req_pick.sv
// Picks the lowest-index set bits of a request mask, one per read port,
// and reports what is left over for the next cycle.
module mtsp_of_req_pick
  import mtsp_of_pkg::*;
#(
  parameter int PAIRS    = 2,
  parameter int RD_PORTS = 1,
  parameter int IDX_W    = 1
) (
  input  logic [PAIRS-1:0]                mask,
  output logic [RD_PORTS-1:0][IDX_W-1:0]  idx,
  output logic [RD_PORTS-1:0]             vld,
  output logic [PAIRS-1:0]                rest
);

  logic [PAIRS-1:0] work;

  // Each port in turn takes the lowest remaining bit and removes it.
  always_comb begin
    work = mask;
    idx  = '0;
    vld  = '0;
    for (int k = 0; k < RD_PORTS; k++) begin
      for (int p = PAIRS - 1; p >= 0; p--) begin
        if (work[p]) begin
          idx[k] = IDX_W'(p);
          vld[k] = 1'b1;
        end
      end
      if (vld[k])
        work[idx[k]] = 1'b0;
    end
    rest = work;
  end

endmodule

// File: rtl/mtsp_of_phase_n.sv
// Operand-fetch phase-N stage: accepts a bundle, issues one GPR read per
// active main/sub pair over RD_PORTS ports (several cycles if needed) and
// presents the bundle downstream once the final batch is on the ports.
module mtsp_of_phase_n
  import mtsp_of_pkg::*;
#(
  parameter int PC_W     = 32,
  parameter int PAIRS    = 2,
  parameter int RD_PORTS = 1,
  localparam int IDX_W   = (PAIRS > 1) ? $clog2(PAIRS) : 1,
  localparam int UW      = 64 * PAIRS
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic                       FLUSH,
  input  logic                       IN_VALID,
  output logic                       IN_READY,
  input  logic [PC_W-1:0]            PC,
  input  logic [UW-1:0]              UINST,
  output logic                       OUT_VALID,
  input  logic                       OUT_READY,
  output logic [PC_W-1:0]            PC_OUT,
  output logic [UW-1:0]              UINST_OUT,
  output logic [RD_PORTS-1:0]        SRC_nEN,
  output logic [GPR_AW*RD_PORTS-1:0] SRC_ADDR,
  output logic [IDX_W*RD_PORTS-1:0]  SRC_PAIR
);

  state_t                        state;
  logic                          accept;
  logic [PAIRS-1:0]              pend;
  logic [PAIRS-1:0]              in_mask;
  logic [PAIRS-1:0]              pick_mask;
  logic [PAIRS-1:0]              rest;
  pair_req_t                     in_req  [PAIRS];
  logic [GPR_AW-1:0]             addr_q  [PAIRS];
  logic [RD_PORTS-1:0][IDX_W-1:0] pick_idx;
  logic [RD_PORTS-1:0]           pick_vld;
  logic [RD_PORTS-1:0]           port_nen_d;
  logic [GPR_AW*RD_PORTS-1:0]    port_addr_d;
  logic [IDX_W*RD_PORTS-1:0]     port_pair_d;

  assign IN_READY  = !FLUSH && (state == IDLE || (state == LAST && OUT_READY));
  assign accept    = IN_VALID && IN_READY;
  assign pick_mask = accept ? in_mask : pend;

  // Decode the incoming bundle into one read request per pair (pair 0 in MSBs).
  always_comb begin
    for (int p = 0; p < PAIRS; p++) begin
      in_req[p] = pair_req(
        UINST[64*(PAIRS-p)-32+F_NEN],
        UINST[64*(PAIRS-p)-32+F_MO_LO +: 2],
        UINST[64*(PAIRS-p)-32+F_DEST_LO +: 5],
        UINST[64*(PAIRS-p)-32+F_SRC_LO +: 5],
        UINST[64*(PAIRS-p)-64+F_NEN],
        UINST[64*(PAIRS-p)-64+F_NALU],
        UINST[64*(PAIRS-p)-64+F_SIB_LO +: 2],
        UINST[64*(PAIRS-p)-64+F_SRC_LO +: 5]);
      in_mask[p] = ~in_req[p].nen;
    end
  end

  mtsp_of_req_pick #(
    .PAIRS    (PAIRS),
    .RD_PORTS (RD_PORTS),
    .IDX_W    (IDX_W)
  ) u_pick (
    .mask (pick_mask),
    .idx  (pick_idx),
    .vld  (pick_vld),
    .rest (rest)
  );

  // Next port values: fresh addresses on acceptance, latched ones while draining.
  always_comb begin
    port_nen_d  = '1;
    port_addr_d = '0;
    port_pair_d = '0;
    for (int k = 0; k < RD_PORTS; k++) begin
      if (pick_vld[k]) begin
        port_nen_d[k] = 1'b0;
        port_addr_d[k*GPR_AW +: GPR_AW] = accept ? in_req[pick_idx[k]].addr
                                                 : addr_q[pick_idx[k]];
        port_pair_d[k*IDX_W +: IDX_W]   = pick_idx[k];
      end
    end
  end

  // Latch the per-pair addresses so later batches need not re-decode the bundle.
  always_ff @(posedge CLK) begin
    if (accept) begin
      for (int p = 0; p < PAIRS; p++)
        addr_q[p] <= in_req[p].addr;
    end
  end

  // Stage control: accept, drain batches in BUSY, hold in LAST until taken.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      pend      <= '0;
      OUT_VALID <= 1'b0;
      PC_OUT    <= '0;
      UINST_OUT <= {(2*PAIRS){NOP}};
      SRC_nEN   <= '1;
      SRC_ADDR  <= '0;
      SRC_PAIR  <= '0;
    end else if (FLUSH) begin
      state     <= IDLE;
      pend      <= '0;
      OUT_VALID <= 1'b0;
      PC_OUT    <= '0;
      UINST_OUT <= {(2*PAIRS){NOP}};
      SRC_nEN   <= '1;
      SRC_ADDR  <= '0;
      SRC_PAIR  <= '0;
    end else if (accept) begin
      PC_OUT    <= PC;
      UINST_OUT <= UINST;
      SRC_nEN   <= port_nen_d;
      SRC_ADDR  <= port_addr_d;
      SRC_PAIR  <= port_pair_d;
      pend      <= rest;
      state     <= (rest == '0) ? LAST : BUSY;
      OUT_VALID <= (rest == '0);
    end else begin
      case (state)
        BUSY: begin
          SRC_nEN  <= port_nen_d;
          SRC_ADDR <= port_addr_d;
          SRC_PAIR <= port_pair_d;
          pend     <= rest;
          if (rest == '0) begin
            state     <= LAST;
            OUT_VALID <= 1'b1;
          end
        end
        LAST: begin
          if (OUT_READY) begin
            state     <= IDLE;
            OUT_VALID <= 1'b0;
            SRC_nEN   <= '1;
            SRC_ADDR  <= '0;
            SRC_PAIR  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
